// File: rtl/pcie_tl_tx_mvc.sv
// -----------------------------------------------------------------------------
// pcie_tl_tx_mvc -- PCIe transaction-layer transmit path with multiple virtual
// channels.
//
// Ingress takes TLPs over an AXI-like address/data handshake pair. Each TLP is
// steered to a per-VC FIFO chosen by its traffic class. An arbiter, either
// round-robin or strict priority, drains the FIFOs into a single egress
// register that feeds the data-link layer.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   aw_valid_i/aw_ready_o write-address handshake
//   w_valid_i/w_ready_o   write-data handshake
//   w_data_i              TLP payload (DATA_W)
//   hdr_i                 TLP header (HDR_W), sampled with the payload
//   tc_i                  traffic class; VC = tc_i & (NUM_VC-1)
//   tlp_valid_o           egress TLP valid
//   tlp_o                 egress TLP {hdr, data}, header in the MSBs
//   tlp_vc_o              VC the egress TLP was drawn from
//   tlp_ready_i           data-link-layer accept
//   vc_empty_o/vc_full_o  per-VC FIFO status from registered counts
// -----------------------------------------------------------------------------
module pcie_tl_tx_mvc #(
   parameter int DATA_W     = 128,
   parameter int HDR_W      = 96,
   parameter int NUM_VC     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int ARB_MODE   = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    aw_valid_i,
   output logic                    aw_ready_o,
   input  logic                    w_valid_i,
   output logic                    w_ready_o,
   input  logic [DATA_W-1:0]       w_data_i,
   input  logic [HDR_W-1:0]        hdr_i,
   input  logic [2:0]              tc_i,
   output logic                    tlp_valid_o,
   output logic [HDR_W+DATA_W-1:0] tlp_o,
   output logic [2:0]              tlp_vc_o,
   input  logic                    tlp_ready_i,
   output logic [NUM_VC-1:0]       vc_empty_o,
   output logic [NUM_VC-1:0]       vc_full_o
);

   localparam int TLP_W = HDR_W + DATA_W;
   localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
   localparam int PAD_W = 1 << VC_W;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {S_IDLE, S_WRITE} state_e;

   // Ingress capture stage
   state_e            state_q;
   logic [TLP_W-1:0]  cap_tlp_q;
   logic [VC_W-1:0]   cap_vc_q;

   // Per-VC FIFOs
   logic [TLP_W-1:0]  mem_q    [NUM_VC][FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
   logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
   logic [CNT_W-1:0]  cnt_q    [NUM_VC];

   // Arbiter and egress register
   logic [VC_W-1:0]   rr_ptr_q;
   logic              tlp_valid_q;
   logic [TLP_W-1:0]  tlp_q;
   logic [2:0]        tlp_vc_q;

   logic [VC_W-1:0]   vc_in;
   logic              in_ready;
   logic              accept;
   logic              push_en;
   logic              any_ne;
   logic              load;
   logic [PAD_W-1:0]  ne_pad;
   logic [VC_W-1:0]   win;
   logic [VC_W-1:0]   rr_next;
   logic [NUM_VC-1:0] push_vec;
   logic [NUM_VC-1:0] pop_vec;

   // ---------------------------------------------------------------- status
   for (genvar v = 0; v < NUM_VC; v++) begin : g_flags
      assign vc_empty_o[v] = (cnt_q[v] == '0);
      assign vc_full_o[v]  = (cnt_q[v] == CNT_W'(FIFO_DEPTH));
   end

   // ---------------------------------------------------------------- ingress
   assign vc_in      = VC_W'(tc_i & 3'(NUM_VC - 1));
   // Only the FIFO the offered TLP targets can stall it.
   assign in_ready   = (state_q == S_IDLE) && !vc_full_o[vc_in];
   assign aw_ready_o = in_ready;
   assign w_ready_o  = in_ready;
   assign accept     = aw_valid_i && w_valid_i && in_ready;
   assign push_en    = (state_q == S_WRITE);

   // ---------------------------------------------------------------- arbiter
   // Zero-padded to a power-of-two width so a wrapping VC_W-bit index is
   // always in range, even for NUM_VC = 1.
   assign ne_pad  = PAD_W'(~vc_empty_o);
   assign any_ne  = ~&vc_empty_o;
   assign load    = (!tlp_valid_q || tlp_ready_i) && any_ne;
   assign rr_next = (NUM_VC == 1) ? '0 : win + 1'b1;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned, which would infer a latch.
      win = '0;
      if (ARB_MODE == 1) begin
         // Ascending scan: the last hit, the highest index, wins.
         for (int i = 0; i < NUM_VC; i++)
            if (ne_pad[VC_W'(i)]) win = VC_W'(i);
      end else begin
         // Descending offset scan: the last hit is the smallest offset from
         // rr_ptr, i.e. the first non-empty VC at or after it.
         for (int i = NUM_VC - 1; i >= 0; i--)
            if (ne_pad[rr_ptr_q + VC_W'(i)]) win = rr_ptr_q + VC_W'(i);
      end
   end

   always_comb begin
      push_vec = '0;
      pop_vec  = '0;
      if (push_en) push_vec[cap_vc_q] = 1'b1;
      if (load)    pop_vec[win]       = 1'b1;
   end

   // ---------------------------------------------------------------- control
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cap_tlp_q   <= '0;
         cap_vc_q    <= '0;
         rr_ptr_q    <= '0;
         tlp_valid_q <= 1'b0;
         tlp_q       <= '0;
         tlp_vc_q    <= '0;
         for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr_q[v] <= '0;
            rd_ptr_q[v] <= '0;
            cnt_q[v]    <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  cap_tlp_q <= {hdr_i, w_data_i};
                  cap_vc_q  <= vc_in;
                  state_q   <= S_WRITE;
               end
            end
            S_WRITE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase

         // Pointers wrap by their natural width since FIFO_DEPTH is 2**PTR_W.
         for (int v = 0; v < NUM_VC; v++) begin
            if (push_vec[v]) wr_ptr_q[v] <= wr_ptr_q[v] + 1'b1;
            if (pop_vec[v])  rd_ptr_q[v] <= rd_ptr_q[v] + 1'b1;
            cnt_q[v] <= cnt_q[v] + CNT_W'(push_vec[v]) - CNT_W'(pop_vec[v]);
         end

         if (load) begin
            tlp_valid_q <= 1'b1;
            tlp_q       <= mem_q[win][rd_ptr_q[win]];
            tlp_vc_q    <= 3'(win);
            if (ARB_MODE == 0) rr_ptr_q <= rr_next;
         end else if (tlp_ready_i) begin
            // Accepted with nothing queued behind it.
            tlp_valid_q <= 1'b0;
         end
      end
   end

   // NOTE: FIFO storage has no reset; pointers and counts define which
   // entries are live, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push_en) mem_q[cap_vc_q][wr_ptr_q[cap_vc_q]] <= cap_tlp_q;
   end

   assign tlp_valid_o = tlp_valid_q;
   assign tlp_o       = tlp_q;
   assign tlp_vc_o    = tlp_vc_q;

endmodule
